ddr3_app_arbiter: RTL

Two-client round-robin arbiter and sequencer for the `ddr3_wrapper` application interface.

- Accepts read and write requests from two independent clients and issues each as one BL8 (512-bit) command/data transaction to the MIG app ports.
- Tracks outstanding reads in issue order and steers returning read data back to the client that issued it.
- Sits in the `ui_clk` domain, directly between the flash/host-side DMA engines and `ddr3_wrapper`.

---
 rtl/ddr3_app_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_app_arbiter.sv
// rtl/ddr3_app_arbiter.sv - two-client round-robin arbiter and sequencer for the MIG app interface
// Issues one BL8 command/data per grant and steers read returns by an in-order tag FIFO.
module ddr3_app_arbiter #(
  parameter int MAX_RD = 16
) (
  input  logic         ui_clk,
  input  logic         ui_clk_sync_rst,
  input  logic         init_calib_complete,
  input  logic         c0_req_valid,
  output logic         c0_req_ready,
  input  logic         c0_req_write,
  input  logic [27:0]  c0_req_addr,
  input  logic [511:0] c0_req_wdata,
  input  logic [63:0]  c0_req_wmask,
  output logic         c0_rsp_valid,
  output logic [511:0] c0_rsp_data,
  input  logic         c1_req_valid,
  output logic         c1_req_ready,
  input  logic         c1_req_write,
  input  logic [27:0]  c1_req_addr,
  input  logic [511:0] c1_req_wdata,
  input  logic [63:0]  c1_req_wmask,
  output logic         c1_rsp_valid,
  output logic [511:0] c1_rsp_data,
  output logic [27:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [511:0] app_wdf_data,
  output logic [63:0]  app_wdf_mask,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_wdf_rdy,
  input  logic [511:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         rd_underflow,
  output logic         busy
);

  localparam int PW = $clog2(MAX_RD);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_rd_count;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic           r_tags [MAX_RD];
  logic           r_last_grant;
  logic           r_cmd_done;
  logic           r_wdf_done;
  logic [27:0]    r_addr;
  logic [2:0]     r_cmd;
  logic [511:0]   r_wdata;
  logic [63:0]    r_wmask;
  logic           r_rsp_valid0;
  logic           r_rsp_valid1;
  logic [511:0]   r_rsp_data;
  logic           r_underflow;

  logic w_credit;
  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;
  logic w_gnt_write;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_app_en;
  logic w_wdf_wren;

  assign w_credit    = r_rd_count < CW'(MAX_RD);
  assign w_elig0     = c0_req_valid && init_calib_complete && (c0_req_write || w_credit);
  assign w_elig1     = c1_req_valid && init_calib_complete && (c1_req_write || w_credit);
  assign w_gnt_any   = w_gnt0 || w_gnt1;
  assign w_gnt_write = w_gnt1 ? c1_req_write : c0_req_write;
  assign w_push      = w_gnt_any && !w_gnt_write;
  // A beat with nothing outstanding has no owner; it is flagged, never popped.
  assign w_pop       = app_rd_data_valid && (r_rd_count != '0);
  assign w_head      = r_tags[r_rd_ptr];

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_app_en    = 1'b0;
    w_wdf_wren  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ui_clk_sync_rst) begin
          // last_grant = 1 means client 1 went last, so client 0 wins a tie.
          w_gnt0 = w_elig0 && (!w_elig1 || r_last_grant);
          w_gnt1 = w_elig1 && (!w_elig0 || !r_last_grant);
          if (w_gnt0 || w_gnt1) begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_app_en   = !r_cmd_done;
        w_wdf_wren = !r_wdf_done;
        if (r_cmd_done && r_wdf_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_cmd_done   <= 1'b0;
      r_wdf_done   <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_cmd        <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_gnt_any) begin
      r_cmd_done   <= 1'b0;
      r_wdf_done   <= !w_gnt_write;
      r_last_grant <= w_gnt1;
      r_addr       <= w_gnt1 ? c1_req_addr  : c0_req_addr;
      r_wdata      <= w_gnt1 ? c1_req_wdata : c0_req_wdata;
      r_wmask      <= w_gnt1 ? c1_req_wmask : c0_req_wmask;
      r_cmd        <= {2'b00, !w_gnt_write};
    end else if (r_state == S_ISSUE) begin
      if (r_cmd_done && r_wdf_done) begin
        r_cmd_done <= 1'b0;
        r_wdf_done <= 1'b0;
      end else begin
        if (w_app_en && app_rdy) begin
          r_cmd_done <= 1'b1;
        end
        if (w_wdf_wren && app_wdf_rdy) begin
          r_wdf_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= w_gnt1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rd_count   <= '0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_data   <= '0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_rsp_data <= app_rd_data;
      end
      case ({w_push, w_pop})
        2'b10:   r_rd_count <= r_rd_count + CW'(1);
        2'b01:   r_rd_count <= r_rd_count - CW'(1);
        default: r_rd_count <= r_rd_count;
      endcase
      r_rsp_valid0 <= w_pop && !w_head;
      r_rsp_valid1 <= w_pop && w_head;
      if (app_rd_data_valid && (r_rd_count == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign c0_req_ready = w_gnt0;
  assign c1_req_ready = w_gnt1;
  assign c0_rsp_valid = r_rsp_valid0;
  assign c1_rsp_valid = r_rsp_valid1;
  assign c0_rsp_data  = r_rsp_data;
  assign c1_rsp_data  = r_rsp_data;
  assign app_addr     = r_addr;
  assign app_cmd      = r_cmd;
  assign app_en       = w_app_en;
  assign app_wdf_data = r_wdata;
  assign app_wdf_mask = r_wmask;
  assign app_wdf_wren = w_wdf_wren;
  assign app_wdf_end  = w_wdf_wren;
  assign rd_underflow = r_underflow;
  assign busy         = (r_state != S_IDLE) || (r_rd_count != '0);

endmodule
